// File: rtl/cnn_window_scheduler.sv
// cnn_window_scheduler: fetches each 5x5 image window from RAM, hands it to the conv stage, then runs the FC stage.
// Define CNN_SCHED_PERF_EN to add the PERF_STALL / PERF_FCWAIT counters.
module cnn_window_scheduler #(
    parameter int IMG_W = 28,
    parameter int K     = 5,
    parameter int PIX_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 MEM_RE,
    output logic [9:0]           MEM_ADDR,
    input  logic [PIX_W-1:0]     MEM_RDATA,
    output logic                 WIN_VALID,
    input  logic                 WIN_READY,
    output logic [4:0]           WIN_X,
    output logic [4:0]           WIN_Y,
    output logic [K*K*PIX_W-1:0] WIN_DATA,
    output logic                 FC_START,
    input  logic                 FC_DONE
`ifdef CNN_SCHED_PERF_EN
    ,
    output logic [15:0]          PERF_STALL,
    output logic [15:0]          PERF_FCWAIT
`endif
);
    localparam int OUT_W = IMG_W - K + 1;
    localparam int KK    = K * K;
    localparam int FW    = $clog2(KK + 1);
    localparam int KW    = $clog2(K);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, FC_WAIT, FIN} state_t;

    state_t               state, nxt;
    logic [4:0]           r, c;
    logic [FW-1:0]        f, slot;
    logic [KW-1:0]        kr, kc;
    logic [K*K*PIX_W-1:0] win_data;
    logic                 fc_sent;
    logic                 accept, xfer, fetch_end, last;
    logic [9:0]           row, col;

    assign accept    = state == IDLE && START;
    assign xfer      = state == ISSUE && WIN_READY;
    assign fetch_end = f == FW'(KK);
    assign last      = r == 5'(OUT_W - 1) && c == 5'(OUT_W - 1);
    assign slot      = f - 1'b1;
    assign row       = 10'(r) + 10'(kr);
    assign col       = 10'(c) + 10'(kc);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = START ? FETCH : IDLE;
            FETCH:   nxt = fetch_end ? ISSUE : FETCH;
            ISSUE:   nxt = !WIN_READY ? ISSUE : (last ? FC_WAIT : FETCH);
            FC_WAIT: nxt = FC_DONE ? FIN : FC_WAIT;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        BUSY      = state != IDLE;
        DONE      = state == FIN;
        MEM_RE    = state == FETCH && !fetch_end;
        MEM_ADDR  = MEM_RE ? row * 10'(IMG_W) + col : '0;
        WIN_VALID = state == ISSUE;
        WIN_X     = r;
        WIN_Y     = c;
        WIN_DATA  = win_data;
        FC_START  = state == FC_WAIT && !fc_sent;
    end

    // f counts fetch cycles; RAM data lags the address by one cycle, so slot f-1 is filled
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r        <= '0;
            c        <= '0;
            f        <= '0;
            kr       <= '0;
            kc       <= '0;
            win_data <= '0;
            fc_sent  <= 1'b0;
        end else begin
            fc_sent <= state == FC_WAIT;
            if (accept) begin
                r  <= '0;
                c  <= '0;
                f  <= '0;
                kr <= '0;
                kc <= '0;
            end
            if (state == FETCH && !fetch_end) begin
                f  <= f + 1'b1;
                kc <= kc == KW'(K - 1) ? '0 : kc + 1'b1;
                kr <= kc == KW'(K - 1) ? kr + 1'b1 : kr;
            end
            if (state == FETCH && f != '0) win_data[slot*PIX_W +: PIX_W] <= MEM_RDATA;
            if (xfer) begin
                f  <= '0;
                kr <= '0;
                kc <= '0;
                c  <= last ? c : (c == 5'(OUT_W - 1) ? '0 : c + 1'b1);
                r  <= !last && c == 5'(OUT_W - 1) ? r + 1'b1 : r;
            end
        end
    end

`ifdef CNN_SCHED_PERF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PERF_STALL  <= '0;
            PERF_FCWAIT <= '0;
        end else if (accept) begin
            PERF_STALL  <= '0;
            PERF_FCWAIT <= '0;
        end else begin
            if (state == ISSUE && !WIN_READY && PERF_STALL != 16'hFFFF) PERF_STALL <= PERF_STALL + 1'b1;
            if (state == FC_WAIT && PERF_FCWAIT != 16'hFFFF) PERF_FCWAIT <= PERF_FCWAIT + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_cnn_window_scheduler.sv
// tb_cnn_window_scheduler: scoreboard bench; expected windows are built straight from the image array.
module tb_cnn_window_scheduler;
    logic         CLK = 1'b0, RST = 1'b0, START = 1'b0, WIN_READY = 1'b0, FC_DONE = 1'b0;
    logic         BUSY, DONE, MEM_RE, WIN_VALID, FC_START;
    logic [9:0]   MEM_ADDR;
    logic [7:0]   MEM_RDATA;
    logic [4:0]   WIN_X, WIN_Y;
    logic [199:0] WIN_DATA;
`ifdef CNN_SCHED_PERF_EN
    logic [15:0]  PERF_STALL, PERF_FCWAIT;
    logic [15:0]  ps, pf;
`endif

    cnn_window_scheduler dut (
        .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE),
        .MEM_RE(MEM_RE), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA),
        .WIN_VALID(WIN_VALID), .WIN_READY(WIN_READY), .WIN_X(WIN_X), .WIN_Y(WIN_Y),
        .WIN_DATA(WIN_DATA), .FC_START(FC_START), .FC_DONE(FC_DONE)
`ifdef CNN_SCHED_PERF_EN
        , .PERF_STALL(PERF_STALL), .PERF_FCWAIT(PERF_FCWAIT)
`endif
    );

    always #5 CLK = ~CLK;

    logic [7:0] img [784];
    always @(posedge CLK) if (MEM_RE) MEM_RDATA <= MEM_ADDR < 10'd784 ? img[MEM_ADDR] : 8'h00;

    typedef struct {
        logic [4:0]   x;
        logic [4:0]   y;
        logic [199:0] d;
    } win_t;
    win_t sb[$];

    int checks = 0, errors = 0;
    int cyc = 0, start_cyc, fc_cyc, fcd_cyc, done_cyc, fc_cnt, done_cnt, fc_pend, xfers;
    int ready_mode, fc_delay, issue_cyc;
    bit start_noise, fc_noise;

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Drives every input once per cycle, #1 after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        issue_cyc = WIN_VALID ? issue_cyc + 1 : 0;
        case (ready_mode)
            0:       WIN_READY = 1'b1;
            1:       WIN_READY = (WIN_X == 0 && WIN_Y == 5 && issue_cyc <= 10) ? 1'b0 : 1'($urandom_range(0, 1));
            default: WIN_READY = issue_cyc >= 3;
        endcase
        START   = start_noise && (WIN_VALID || DONE) && $urandom_range(0, 2) == 0;
        FC_DONE = fc_noise && MEM_RE && $urandom_range(0, 7) == 0;
        if (fc_pend > 0) begin
            fc_pend--;
            if (fc_pend == 0) begin
                FC_DONE = 1'b1;
                fcd_cyc = cyc;
            end
        end
        if (FC_START) begin
            fc_cyc = cyc;
            fc_cnt++;
            fc_pend = fc_delay;
        end
        if (DONE) begin
            done_cyc = cyc;
            done_cnt++;
`ifdef CNN_SCHED_PERF_EN
            ps = PERF_STALL;
            pf = PERF_FCWAIT;
`endif
        end
    endtask

    task automatic push_expected();
        win_t e;
        sb.delete();
        for (int r = 0; r < 24; r++)
            for (int c = 0; c < 24; c++) begin
                e.x = 5'(r);
                e.y = 5'(c);
                for (int k = 0; k < 5; k++)
                    for (int l = 0; l < 5; l++)
                        e.d[(k*5+l)*8 +: 8] = img[(r+k)*28 + c + l];
                sb.push_back(e);
            end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_done"}, DONE, 0);
        chk({tag, "_mem_re"}, MEM_RE, 0);
        chk({tag, "_mem_addr"}, MEM_ADDR, 0);
        chk({tag, "_win_valid"}, WIN_VALID, 0);
        chk({tag, "_win_x"}, WIN_X, 0);
        chk({tag, "_win_y"}, WIN_Y, 0);
        chk({tag, "_win_data"}, WIN_DATA, 0);
        chk({tag, "_fc_start"}, FC_START, 0);
`ifdef CNN_SCHED_PERF_EN
        chk({tag, "_perf_stall"}, PERF_STALL, 0);
        chk({tag, "_perf_fcwait"}, PERF_FCWAIT, 0);
`endif
    endtask

    task automatic begin_image();
        push_expected();
        done_cnt = 0;
        fc_cnt   = 0;
        fc_pend  = 0;
        xfers    = 0;
        START    = 1'b1;
        tick();
        start_cyc = cyc;
        chk("start_busy", BUSY, 1);
        chk("start_mem_re", MEM_RE, 1);
        chk("start_mem_addr", MEM_ADDR, 0);
    endtask

    task automatic run_image();
        int n;
        begin_image();
        n = 0;
        while (done_cnt == 0 && n < 25000) begin
            tick();
            n++;
        end
        if (done_cnt == 0) chk("done_timeout", 0, 1);
        for (int i = 0; i < 5; i++) tick();
        chk("done_pulses", done_cnt, 1);
        chk("fc_start_pulses", fc_cnt, 1);
        chk("window_transfers", xfers, 576);
        chk("scoreboard_empty", sb.size(), 0);
        chk("end_busy", BUSY, 0);
    endtask

    // Monitor: pops the scoreboard on every transfer and watches stall stability.
    initial begin
        win_t e;
        logic hold = 1'b0, pend_fetch = 1'b0;
        logic [4:0] hx = '0, hy = '0;
        logic [199:0] hd = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                hold = 1'b0;
                pend_fetch = 1'b0;
            end else begin
                if (pend_fetch) begin
                    chk("next_fetch_re", MEM_RE, 1);
                    if (sb.size() > 0) chk("next_fetch_addr", MEM_ADDR, sb[0].x * 28 + sb[0].y);
                    pend_fetch = 1'b0;
                end
                if (WIN_VALID) begin
                    chk("issue_mem_re", MEM_RE, 0);
                    if (hold) begin
                        chk("stall_win_x", WIN_X, hx);
                        chk("stall_win_y", WIN_Y, hy);
                        chk("stall_win_data", WIN_DATA, hd);
                    end
                end
                if (WIN_VALID && WIN_READY) begin
                    xfers++;
                    if (sb.size() == 0) chk("unexpected_window", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("win_x", WIN_X, e.x);
                        chk("win_y", WIN_Y, e.y);
                        chk("win_data", WIN_DATA, e.d);
                        pend_fetch = sb.size() > 0;
                    end
                end
                hold = WIN_VALID && !WIN_READY;
                hx = WIN_X;
                hy = WIN_Y;
                hd = WIN_DATA;
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 784; i++) img[i] = 8'(i);
        ready_mode = 0;
        fc_delay = 3;
        start_noise = 1'b0;
        fc_noise = 1'b0;
        issue_cyc = 0;
        RST = 1'b1;
        tick();
        tick();
        check_zero("reset");
        RST = 1'b0;
        tick();
        chk("idle_busy", BUSY, 0);

        // Image = address mod 256, ready tied high, FC_DONE 3 cycles after FC_START.
        run_image();
        chk("fc_start_edge", fc_cyc - start_cyc + 1, 15553);
        chk("done_after_fc_start", done_cyc - fc_cyc, 4);

        // Random image and ready, (0,5) stalled 10 cycles, stray START/FC_DONE, slow FC.
        for (int i = 0; i < 784; i++) img[i] = 8'($urandom);
        ready_mode = 1;
        start_noise = 1'b1;
        fc_noise = 1'b1;
        fc_delay = 50;
        run_image();
        chk("done_after_fc_done", done_cyc - fcd_cyc, 1);
        start_noise = 1'b0;
        fc_noise = 1'b0;

        // Reset in the middle of window (3,7), fetch index 12.
        ready_mode = 2;
        fc_delay = 3;
        begin_image();
        n = 0;
        while (!(WIN_X == 3 && WIN_Y == 7 && MEM_RE && MEM_ADDR == 10'd149) && n < 5000) begin
            tick();
            n++;
        end
        chk("reach_3_7_f12", n < 5000, 1);
        RST = 1'b1;
        #1;
        check_zero("async_reset");
        tick();
        RST = 1'b0;
        sb.delete();
        tick();
        check_zero("after_reset");

        // Full image, ready low for 2 cycles on every window.
        run_image();
`ifdef CNN_SCHED_PERF_EN
        chk("perf_stall", ps, 1152);
        chk("perf_fcwait", pf, 4);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
